// File: rtl/l3_cache_ctrl.sv
// Control FSM for the L3 cache datapath: request latch, tag lookup, hit read/write,
// miss handling through the lower-level FIFO (eviction, line request, fill, replay).
module l3_cache_ctrl #(
    parameter int FILL_TIMEOUT = 1024,
    parameter int TO_W         = 10
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       cpu_req,
    input  logic       cpu_rw,
    output logic       cpu_ready,
    output logic       cpu_done,
    output logic       cpu_err,
    input  logic       Hit,
    input  logic       Desalojo,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic       fifo_push,
    output logic       fifo_pop,
    output logic       Lectura_Escritura,
    output logic       Clear_Main_REG,
    output logic       Clear_Tag_Banks,
    output logic       Clear_Formador,
    output logic       Clear_LDG_REG,
    output logic       Eneable_Main_REG,
    output logic       Eneable_Formador,
    output logic       Eneable_REG,
    output logic       Bank_Eneable,
    output logic       Write_Eneable,
    output logic       Sel_Mux_Bank,
    output logic [1:0] Sel_Mux_Mem,
    output logic       R_W
);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_LATCH, S_LOOKUP, S_HIT_WR, S_RESP,
        S_EV_FORM, S_EV_PUSH, S_RQ_FORM, S_RQ_PUSH,
        S_WAIT_FILL, S_FILL_LATCH, S_FILL_WR, S_ABORT
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FILL_TIMEOUT - 1);

    state_t          state, next_state;
    logic [1:0]      way_sel;   // bit 0 doubles as the saved eviction flag
    logic            replay;
    logic [TO_W-1:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= S_INIT;
            R_W      <= 1'b0;
            way_sel  <= 2'b00;
            replay   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    replay <= 1'b0;
                    if (cpu_req) R_W <= cpu_rw;
                end
                S_LOOKUP: begin
                    if (!Hit && !replay) way_sel <= Desalojo ? 2'b01 : 2'b00;
                end
                S_WAIT_FILL: begin
                    if (!fifo_empty) wait_cnt <= '0;
                    else             wait_cnt <= wait_cnt + 1'b1;
                end
                S_FILL_WR: replay <= 1'b1;
                S_RESP, S_ABORT: begin
                    replay   <= 1'b0;
                    wait_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state        = state;
        cpu_ready         = 1'b0;
        cpu_done          = 1'b0;
        cpu_err           = 1'b0;
        fifo_push         = 1'b0;
        fifo_pop          = 1'b0;
        Lectura_Escritura = 1'b0;
        Clear_Main_REG    = 1'b0;
        Clear_Tag_Banks   = 1'b0;
        Clear_Formador    = 1'b0;
        Clear_LDG_REG     = 1'b0;
        Eneable_Main_REG  = 1'b0;
        Eneable_Formador  = 1'b0;
        Eneable_REG       = 1'b0;
        Bank_Eneable      = 1'b0;
        Write_Eneable     = 1'b0;
        Sel_Mux_Bank      = 1'b0;
        Sel_Mux_Mem       = 2'b00;
        case (state)
            S_INIT: begin
                Clear_Main_REG  = 1'b1;
                Clear_Tag_Banks = 1'b1;
                Clear_Formador  = 1'b1;
                Clear_LDG_REG   = 1'b1;
                next_state      = S_IDLE;
            end
            S_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) next_state = S_LATCH;
            end
            S_LATCH: begin
                Eneable_Main_REG = 1'b1;
                next_state       = S_LOOKUP;
            end
            S_LOOKUP: begin
                Bank_Eneable = 1'b1;
                Sel_Mux_Mem  = 2'b10;
                if (Hit)         next_state = R_W ? S_HIT_WR : S_RESP;
                else if (replay) next_state = S_ABORT;  // filled line must hit; no second fill
                else             next_state = Desalojo ? S_EV_FORM : S_RQ_FORM;
            end
            S_HIT_WR: begin
                Bank_Eneable  = 1'b1;
                Write_Eneable = 1'b1;
                Eneable_REG   = 1'b1;
                Sel_Mux_Mem   = 2'b10;
                next_state    = S_RESP;
            end
            S_RESP: begin
                cpu_done   = 1'b1;
                next_state = S_IDLE;
            end
            S_EV_FORM, S_RQ_FORM: begin
                Eneable_Formador = 1'b1;
                Sel_Mux_Mem      = way_sel;
                next_state       = (state == S_EV_FORM) ? S_EV_PUSH : S_RQ_PUSH;
            end
            S_EV_PUSH, S_RQ_PUSH: begin
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    next_state = (state == S_EV_PUSH) ? S_RQ_FORM : S_WAIT_FILL;
                end
            end
            S_WAIT_FILL: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = S_FILL_LATCH;
                end else if (wait_cnt == TO_LAST) begin
                    next_state = S_ABORT;
                end
            end
            S_FILL_LATCH: begin
                Lectura_Escritura = 1'b1;
                Eneable_Main_REG  = 1'b1;
                next_state        = S_FILL_WR;
            end
            S_FILL_WR: begin
                Lectura_Escritura = 1'b1;
                Bank_Eneable      = 1'b1;
                Write_Eneable     = 1'b1;
                Eneable_REG       = 1'b1;
                Sel_Mux_Bank      = 1'b1;
                Sel_Mux_Mem       = way_sel;
                next_state        = S_LATCH;
            end
            S_ABORT: begin
                cpu_done      = 1'b1;
                cpu_err       = 1'b1;
                Clear_LDG_REG = 1'b1;
                next_state    = S_IDLE;
            end
            default: next_state = S_INIT;
        endcase
        // A FIFO side effect in the reset cycle would desynchronise the lower level.
        if (Reset) begin
            fifo_push = 1'b0;
            fifo_pop  = 1'b0;
        end
    end

endmodule
